// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
// Holds the mode encoding, the counter direction type and the reset
// defaults for the period and duty registers.
package pwm_pkg;

  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned DEFAULT_PERIOD = 32'd1;
  localparam int unsigned DEFAULT_DUTY   = 32'd0;

endpackage

// File: rtl/pwm_multi_if.sv
// Configuration bus between the register block and the PWM core.
// Ports (master drives, slave receives):
//   enable   - run enable
//   load     - one-cycle strobe capturing the fields below into shadow regs
//   period   - period value P
//   duty     - per-channel duty, channel i at [i*CNT_W +: CNT_W]
//   mode     - 0 edge-aligned, 1 centre-aligned
//   polarity - per-channel output inversion
interface pwm_multi_if #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 16
);
  logic                    enable;
  logic                    load;
  logic [CNT_W-1:0]        period;
  logic [CH_NUM*CNT_W-1:0] duty;
  logic                    mode;
  logic [CH_NUM-1:0]       polarity;

  modport master (output enable, load, period, duty, mode, polarity);
  modport slave  (input  enable, load, period, duty, mode, polarity);
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty and polarity, compare and output flop.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   enable     - run enable (low drives the inactive level)
//   load       - capture duty/polarity into the shadow registers
//   commit     - copy shadow into active this cycle (also bypassed to compare)
//   duty       - duty value to shadow
//   polarity   - polarity bit to shadow
//   cnt        - shared period counter
//   pwm        - registered PWM output
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             commit,
  input  logic [CNT_W-1:0] duty,
  input  logic             polarity,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_sh_r;
  logic [CNT_W-1:0] duty_act_r;
  logic [CNT_W-1:0] duty_eff_s;
  logic             pol_sh_r;
  logic             pol_act_r;
  logic             pol_eff_s;
  logic             raw_s;
  logic             pwm_r;

  // Values being committed are used by the compare in the commit cycle itself
  always_comb begin
    duty_eff_s = duty_act_r;
    pol_eff_s  = pol_act_r;
    if (commit) begin
      duty_eff_s = duty_sh_r;
      pol_eff_s  = pol_sh_r;
    end else begin
      duty_eff_s = duty_act_r;
      pol_eff_s  = pol_act_r;
    end
    raw_s = (cnt < duty_eff_s);
  end

  // Shadow capture on load, active update on commit (commit sees pre-load shadow)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_sh_r  <= CNT_W'(DEFAULT_DUTY);
      duty_act_r <= CNT_W'(DEFAULT_DUTY);
      pol_sh_r   <= 1'b0;
      pol_act_r  <= 1'b0;
    end else begin
      if (load) begin
        duty_sh_r <= duty;
        pol_sh_r  <= polarity;
      end
      if (commit) begin
        duty_act_r <= duty_sh_r;
        pol_act_r  <= pol_sh_r;
      end
    end
  end

  // Output flop: inactive level while disabled, zero only during reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= enable ? (raw_s ^ pol_eff_s) : pol_eff_s;
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with one shared period counter.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   cfg          - configuration bus (enable, load, period, duty, mode, polarity)
//   pwm_o        - registered per-channel PWM outputs
//   period_start - registered one-cycle pulse per period boundary
//   cnt_o        - current counter value
// Period, mode, duty and polarity are double-buffered; a pending shadow is
// committed at the next period boundary, or at once while disabled.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  pwm_multi_if.slave        cfg,
  output logic [CH_NUM-1:0] pwm_o,
  output logic              period_start,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  dir_e             dir_r;
  dir_e             dir_nxt_s;
  logic [CNT_W-1:0] period_sh_r;
  logic [CNT_W-1:0] period_act_r;
  logic [CNT_W-1:0] period_eff_s;
  logic [CNT_W-1:0] pe_s;
  logic [CNT_W-1:0] pe_last_s;
  logic             mode_sh_r;
  logic             mode_act_r;
  logic             mode_eff_s;
  logic             pending_r;
  logic             boundary_s;
  logic             commit_s;
  logic             period_start_r;

  // Boundary detection, commit decision and bypassed period/mode
  always_comb begin
    boundary_s   = cfg.enable && (cnt_r == ZERO) && (dir_r == DIR_UP);
    commit_s     = pending_r && (boundary_s || !cfg.enable);
    period_eff_s = commit_s ? period_sh_r : period_act_r;
    mode_eff_s   = commit_s ? mode_sh_r : mode_act_r;
    pe_s         = (period_eff_s == ZERO) ? ONE : period_eff_s;
    pe_last_s    = pe_s - ONE;
  end

  // Counter/direction next state; centre mode holds each endpoint for two cycles
  always_comb begin
    cnt_nxt_s = cnt_r;
    dir_nxt_s = dir_r;
    if (!cfg.enable) begin
      cnt_nxt_s = ZERO;
      dir_nxt_s = DIR_UP;
    end else if (mode_eff_s == PWM_MODE_EDGE) begin
      dir_nxt_s = DIR_UP;
      cnt_nxt_s = (cnt_r >= pe_last_s) ? ZERO : (cnt_r + ONE);
    end else if (mode_eff_s == PWM_MODE_CENTER) begin
      case (dir_r)
        DIR_UP: begin
          if (cnt_r >= pe_last_s) begin
            dir_nxt_s = DIR_DOWN;
          end else begin
            cnt_nxt_s = cnt_r + ONE;
          end
        end
        DIR_DOWN: begin
          if (cnt_r == ZERO) begin
            dir_nxt_s = DIR_UP;
          end else begin
            cnt_nxt_s = cnt_r - ONE;
          end
        end
        default: begin
          cnt_nxt_s = ZERO;
          dir_nxt_s = DIR_UP;
        end
      endcase
    end else begin
      cnt_nxt_s = ZERO;
      dir_nxt_s = DIR_UP;
    end
  end

  // Counter and direction state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= ZERO;
      dir_r <= DIR_UP;
    end else begin
      cnt_r <= cnt_nxt_s;
      dir_r <= dir_nxt_s;
    end
  end

  // Shadow/active period and mode plus pending flag; a load wins over a commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_sh_r  <= CNT_W'(DEFAULT_PERIOD);
      period_act_r <= CNT_W'(DEFAULT_PERIOD);
      mode_sh_r    <= PWM_MODE_EDGE;
      mode_act_r   <= PWM_MODE_EDGE;
      pending_r    <= 1'b0;
    end else begin
      if (cfg.load) begin
        period_sh_r <= cfg.period;
        mode_sh_r   <= cfg.mode;
      end
      if (commit_s) begin
        period_act_r <= period_sh_r;
        mode_act_r   <= mode_sh_r;
      end
      if (cfg.load) begin
        pending_r <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Registered period-start pulse, aligned with the PWM outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_start_r <= 1'b0;
    end else begin
      period_start_r <= boundary_s;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : gen_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (cfg.enable),
      .load     (cfg.load),
      .commit   (commit_s),
      .duty     (cfg.duty[i*CNT_W +: CNT_W]),
      .polarity (cfg.polarity[i]),
      .cnt      (cnt_r),
      .pwm      (pwm_o[i])
    );
  end

  assign period_start = period_start_r;
  assign cnt_o        = cnt_r;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel, parametrised PWM generator sharing one period counter across CH_NUM channels.
- Each channel has its own duty value and polarity.
- Edge-aligned and centre-aligned modes.
- Double-buffered (shadow) period/duty/mode registers, committed only at period boundaries for glitch-free updates.
- Sits behind the Avalon slave register block, which drives the load strobe and configuration buses.

Parameters:
CH_NUM, 4, number of PWM channels (1..16)
CNT_W, 16, width of counter, period and duty values (2..32)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run enable; low = counter parked, outputs inactive
load  in  1  single-cycle strobe; captures period/duty/mode/polarity into shadow registers
period  in  CNT_W  period value P (cycles per period in edge mode; half-period in centre mode)
duty  in  CH_NUM*CNT_W  per-channel duty D; channel i at bits [i*CNT_W +: CNT_W]
mode  in  1  0 = edge-aligned, 1 = centre-aligned
polarity  in  CH_NUM  per-channel output inversion (1 = active-low output)
pwm_o  out  CH_NUM  registered PWM outputs
period_start  out  1  registered pulse, high for one cycle at the start of each period
cnt_o  out  CNT_W  current counter value (debug/capture)

Behaviour:
- Reset (async assert, sync release by clk):
  - cnt = 0, dir = up.
  - Shadow and active period = 1, duty = 0, mode = 0, polarity = 0; pending = 0.
  - pwm_o = 0, period_start = 0.
- Effective period: Pe = (P_act == 0) ? 1 : P_act.
- Edge mode: cnt runs 0,1,…,Pe-1, then 0. Period = Pe cycles.
- Centre mode: cnt runs up 0..Pe-1, then down Pe-1..0. Each endpoint is held two cycles (direction flip). Period = 2*Pe cycles.
- Compare: raw_i = (cnt < D_act[i]).
  - High time is min(D,Pe) cycles in edge mode and 2*min(D,Pe) in centre mode.
  - D = 0 gives always low; D >= Pe gives always high. No single-cycle glitch at either end.
- Output: pwm_o[i] <= enable ? (raw_i ^ pol_act[i]) : pol_act[i]. One cycle of latency from cnt to pin. While disabled, each output sits at its inactive level.
- Period boundary (cycle in which cnt == 0 and dir == up):
  - period_start <= 1.
  - If pending: active regs <= shadow, pending <= 0. New values apply from this cycle's compare onward (same-cycle bypass from shadow).
- Load:
  - Shadow <= inputs, pending <= 1.
  - A load in the boundary cycle is NOT committed at that boundary; it commits at the next one. The boundary commit uses the pre-load shadow.
  - Back-to-back loads before a boundary: last one wins.
- Enable low:
  - cnt held at 0, dir = up, period_start = 0.
  - Any pending shadow commits immediately (next cycle). A load while disabled takes effect on the next cycle.
- Enable rising: first enabled cycle is a boundary (cnt = 0); period_start pulses.
- Mode change: applied only at a boundary via commit. Centre-to-edge and edge-to-centre both restart cleanly from cnt = 0, dir = up.
- Period shrink: committed only at a boundary, so cnt is always < new Pe. Counter wrap beyond Pe cannot occur.
- Arithmetic: all compares unsigned, CNT_W wide. No carry out of cnt; max Pe = 2^CNT_W - 1.
- Reset asserted mid-period: everything returns to reset values asynchronously; outputs drop to 0 (not polarity level) until the first clock after release.

Decomposition:
- Shared package pwm_pkg:
  - Mode encoding constants (PWM_MODE_EDGE = 0, PWM_MODE_CENTER = 1).
  - Default period/duty constants.
- Sub-module pwm_channel (one per channel, via generate): holds shadow/active duty and polarity, does the compare and output register.
- Top: counter, direction FSM (UP/DOWN), commit/pending logic, period_start.

Test Plan:
1. CNT_W=8, edge, P=10, D0=3, D1=0, D2=10, D3=255, enable → pwm_o[0] high 3 of every 10 cycles; ch1 constant 0; ch2 and ch3 constant 1; period_start every 10 cycles.
2. Centre, P=8, D0=3 → cnt sequence 0..7,7..0; pwm_o[0] high 6 consecutive cycles of 16 (ends wrap across boundary), symmetric about the cnt = 0 point; period_start every 16 cycles.
3. Mid-period load (cnt=4, P=10→6, D0 3→5) → no change until next cnt = 0; then 6-cycle period with 5 high. Load exactly at boundary → commit deferred one full period.
4. polarity[1]=1, D1=2, P=4 → pwm_o[1] low 2 / high 2. Enable deassert → pwm_o[1] = 1, others 0, cnt = 0 within one cycle.
5. P=0, D0=1 (edge) → Pe = 1: pwm_o[0] constant 1, period_start constant 1 while enabled.
6. Reset asserted at cnt=5 in centre mode → pwm_o, period_start, cnt = 0 immediately. After release and enable: restarts with P=1, D=0 defaults until a load.
